// File: rtl/uart_pkg.sv
// Shared constants for the UART: receiver state encoding, register map and
// status bit positions.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_START = START,
    ST_DATA  = DATA,
    ST_STOP  = STOP
  } rx_state_t;

  localparam logic [2:0] XMITDT = 3'd0;
  localparam logic [2:0] STATUS = 3'd1;
  localparam logic [2:0] DIVLSB = 3'd2;
  localparam logic [2:0] DIVMSB = 3'd3;
  localparam logic [2:0] RECVDT = 3'd4;
  localparam logic [2:0] CLRINT = 3'd7;

  localparam int TRANSMITTING = 0;
  localparam int RECEIVING    = 1;
  localparam int DONE_XMT     = 2;
  localparam int DONE_RCV     = 3;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset to
// RESET_VALUE; RESET_LEVEL selects which level of i_rst is the active one.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_LEVEL = 1'b0,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  generate
    if (RESET_LEVEL == 1'b0) begin : g_rst_low
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          r_meta <= RESET_VALUE;
          r_q    <= RESET_VALUE;
        end else begin
          r_meta <= i_d;
          r_q    <= r_meta;
        end
      end
    end else begin : g_rst_high
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_meta <= RESET_VALUE;
          r_q    <= RESET_VALUE;
        end else begin
          r_meta <= i_d;
          r_q    <= r_meta;
        end
      end
    end
  endgenerate

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: hunts for a start bit, samples each bit mid-period
// LSB first, and hands finished bytes to a one-deep holding register.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 din,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 rx_ack,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 receiving,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_int
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 w_din_s;
  logic                 r_din_d;
  logic                 w_start_edge;
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic [DIV_WIDTH-1:0] r_div_l;
  logic [DIV_WIDTH-1:0] w_div_in;
  logic [DIV_WIDTH-1:0] w_half;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_half_hit;
  logic                 w_bit_hit;
  logic                 w_last_bit;
  logic                 w_sample_bit;
  logic                 w_stop_ok;
  logic                 w_stop_bad;

  uart_sync2 #(
    .RESET_LEVEL (1'b0),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .i_clk (clkin),
    .i_rst (reset),
    .i_d   (din),
    .o_q   (w_din_s)
  );

  // A divisor below 2 would leave no room for a half-bit sample point.
  assign w_div_in     = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;
  assign w_half       = r_div_l >> 1;
  assign w_start_edge = r_din_d & ~w_din_s;
  assign w_half_hit   = (r_cnt == w_half - DIV_WIDTH'(1));
  assign w_bit_hit    = (r_cnt == r_div_l - DIV_WIDTH'(1));
  assign w_last_bit   = (r_bit_idx == IDX_W'(DATA_BITS - 1));
  assign w_sample_bit = (r_state == ST_DATA) && w_bit_hit;
  assign w_stop_ok    = (r_state == ST_STOP) && w_bit_hit && w_din_s;
  assign w_stop_bad   = (r_state == ST_STOP) && w_bit_hit && !w_din_s;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + DIV_WIDTH'(1);
    w_bit_idx_next = r_bit_idx;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_start_edge) w_state_next = ST_START;
      end
      ST_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (w_half_hit) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_din_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_hit) begin
          w_cnt_next = '0;
          if (w_last_bit) w_state_next = ST_STOP;
          else            w_bit_idx_next = r_bit_idx + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (w_bit_hit) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_din_d <= 1'b1;
      r_div_l <= DIV_WIDTH'(2);
      r_shift <= '0;
    end else begin
      r_din_d <= w_din_s;
      if (r_state == ST_IDLE && w_start_edge) r_div_l <= w_div_in;
      if (w_sample_bit) r_shift[r_bit_idx] <= w_din_s;
    end
  end

  // Sticky flags: a set in the same cycle as clr_err takes priority.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_stop_ok) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rx_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
      end
      if (w_stop_bad)   r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
      if (w_stop_ok && r_rx_valid && !rx_ack) r_overrun <= 1'b1;
      else if (clr_err)                       r_overrun <= 1'b0;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign receiving = (r_state != ST_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_int    = r_rx_valid | r_frame_err;

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Synthesizable serial receive front end for the single UART.
- Consumes the asynchronous serial line `din`, using the same 16-bit bit-period divisor held in the UART's DIVMSB/DIVLSB registers.
- Hunts for start bits and samples mid-bit, LSB first; delivers each byte into a one-deep holding register with a valid/ack handshake.
- Its outputs feed the RECVDT register, the RECEIVING/DONE_RCV status bits and the interrupt request.

Parameters:
- DATA_BITS, 8, data bits per frame (no parity, 1 stop bit).
- DIV_WIDTH, 16, width of the divisor input, in clkin cycles per bit.

Ports:
- clkin  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  1  serial line; idle high; asynchronous to clkin.
- divisor  in  DIV_WIDTH  bit period in clkin cycles.
- rx_ack  in  1  consumer pop; clears rx_valid.
- clr_err  in  1  clears frame_err and overrun.
- rx_data  out  DATA_BITS  holding register.
- rx_valid  out  1  holding register full.
- receiving  out  1  high in any state other than IDLE.
- frame_err  out  1  sticky; stop bit sampled low.
- overrun  out  1  sticky; byte completed while rx_valid was held.
- rx_int  out  1  equals rx_valid OR frame_err.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; both synchronizer flops=1; counters=0.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, receiving=0.
  - Applies mid-frame: the partial byte is discarded. After release, reception restarts only on a new falling edge.
- Synchronizer: din passes two flops to give din_s; din_d holds the previous din_s. A start edge is din_d=1 and din_s=0.
- Divisor:
  - Latched into div_l on the start edge.
  - Values 0 or 1 are forced to 2.
  - half = div_l>>1.
  - Changing divisor mid-frame has no effect until the next frame.
- State machine: IDLE, START, DATA, STOP. Counter cnt is DIV_WIDTH bits, bit_idx is clog2(DATA_BITS) bits.
  - IDLE: on a start edge, go to START with cnt=0.
  - START: cnt increments. At cnt==half-1, sample din_s:
    - 0: go to DATA, cnt=0, bit_idx=0.
    - 1: glitch; go to IDLE, no flags set.
  - DATA: at cnt==div_l-1, shift din_s into shift[bit_idx] (LSB first) and set cnt=0. After bit DATA_BITS-1, go to STOP; otherwise bit_idx+1.
  - STOP: at cnt==div_l-1, sample din_s and go to IDLE.
    - din_s=1: next cycle rx_data=shift and rx_valid=1.
    - din_s=0: next cycle frame_err=1; rx_data and rx_valid are unchanged.
- Latency: rx_valid rises 1 cycle after the stop sample, i.e. 2 + half + 9·div_l cycles after the din falling edge (±1 for synchronizer phase).
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next cycle.
  - rx_ack with rx_valid=0 is ignored.
- Completion with rx_valid=1 and no rx_ack in the same cycle: rx_data is overwritten with the new byte, overrun=1, rx_valid stays 1.
- Completion and rx_ack in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- clr_err clears both sticky flags. If a flag is set in the same cycle as clr_err, the set wins.
- Back-to-back frames: IDLE accepts a new start edge in the cycle after STOP exits.
- After a frame error the line may still be low; IDLE waits for a fresh 1→0 edge.

Decomposition:
- Package uart_pkg holds:
  - rx state encoding localparams: IDLE=0, START=1, DATA=2, STOP=3;
  - the register address constants (XMITDT=0, STATUS=1, DIVLSB=2, DIVMSB=3, RECVDT=4, CLRINT=7);
  - status bit indices (TRANSMITTING=0, RECEIVING=1, DONE_XMT=2, DONE_RCV=3).
- One sub-module: uart_sync2 (two-flop synchronizer, reset value 1, parameterized reset level). Everything else stays in one module.

Test Plan:
- divisor=16, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit → rx_data=0xA5, rx_valid=1 at 154±1 cycles after the edge, frame_err=0.
- divisor=16, din low for 5 cycles then high → no rx_valid, receiving returns to 0 by cycle 11, no flags set.
- divisor=16, send 0x3C with stop bit driven 0 → frame_err=1, rx_valid=0, rx_int=1. Then clr_err → frame_err=0 and the next 0x3C is received cleanly.
- divisor=8, send 0x11 then 0x22 back-to-back with no ack → rx_data=0x22, overrun=1. Repeat with rx_ack pulsed on the completion cycle → overrun=0.
- divisor=16, assert reset during data bit 3 → all outputs 0 immediately; release, send 0x7E → rx_data=0x7E.
- divisor=16, change divisor to 32 mid-frame (0x5A) → byte still decodes 0x5A; the next frame decodes correctly at 32 clk/bit. divisor=0 → behaves as 2.
